idp_seq: RTL

- Bit-serial sequencer that sits directly in front of, and directly behind, the idp path-cost compare element.
- Accepts one parallel neighbour candidate (cost, root, direction, path function) over a valid/ready handshake.
- Drives the PE through COST, ROOT and SAVE phases, serialising operands LSB first.
- Deserialises the PE's result_data stream and the sampled conquest flag into a parallel result word, returned on a second valid/ready handshake.

---
 rtl/idp_pkg.sv | 33 +++
 rtl/idp_seq_shreg.sv | 37 +++
 rtl/idp_seq.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/idp_pkg.sv
// Shared definitions for the idp path-cost sequencer: PE phase codes,
// path-function codes, sequencer FSM states and default field widths.
package idp_pkg;

    typedef enum logic [1:0] {
        STOP_ST = 2'b00,
        COST_ST = 2'b01,
        ROOT_ST = 2'b10,
        SAVE_ST = 2'b11
    } pe_state_e;

    // Path-function codes: additive cost vs. max-arc cost
    localparam logic C8L16 = 1'b0;
    localparam logic C16L8 = 1'b1;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_COST,
        SEQ_ROOT,
        SEQ_SAVE,
        SEQ_DONE
    } seq_state_e;

    localparam int DEF_COST_W = 8;
    localparam int DEF_ROOT_W = 16;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/idp_seq_shreg.sv
// Load/shift-right register: parallel load, or shift with a new bit entering
// at the MSB. Serves both as operand serialiser and result deserialiser.
module idp_seq_shreg #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         shift_i,
    input  logic         shift_in_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_d;
    logic [W-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = load_val_i;
        end else if (shift_i) begin
            data_d = {shift_in_i, data_q[W-1:1]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/idp_seq.sv
// Bit-serial sequencer around the idp path-cost compare element.
// Optional macro IDP_SEQ_STAT_EN adds saturating candidate/conquest counters.
module idp_seq
    import idp_pkg::*;
#(
    parameter int COST_W = DEF_COST_W,
    parameter int ROOT_W = DEF_ROOT_W,
    parameter int RES_W  = COST_W + ROOT_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [COST_W-1:0] in_cost,
    input  logic [ROOT_W-1:0] in_root,
    input  logic              in_dir,
    input  logic              in_pathfunction,
    output logic [1:0]        pe_state,
    output logic              pe_pathfunction,
    output logic              pe_direction,
    output logic              pe_root_carry_in,
    output logic              pe_extern_data,
    input  logic              pe_result_data,
    input  logic              pe_conquest,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RES_W-1:0]  out_word,
    output logic              out_conquest
`ifdef IDP_SEQ_STAT_EN
    ,
    output logic [15:0]       stat_cand,
    output logic [15:0]       stat_conq
`endif
);

    localparam int CNT_W = $clog2(max3(COST_W, ROOT_W, RES_W) + 1);
    localparam int OP_W  = COST_W + ROOT_W;

    seq_state_e state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic dir_d, dir_q;
    logic pf_d, pf_q;
    logic conq_d, conq_q;

    logic op_load, op_shift, res_shift;
    logic accept, out_hs;
    pe_state_e pe_st;
    logic [OP_W-1:0] op_q;
    logic [RES_W-1:0] res_q;
    logic unused_op_hi;

    // Operand word holds {root, cost} so cost bits leave first, then root bits
    idp_seq_shreg #(.W(OP_W)) u_op_ser (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (op_load),
        .load_val_i ({in_root, in_cost}),
        .shift_i    (op_shift),
        .shift_in_i (1'b0),
        .q_o        (op_q)
    );

    idp_seq_shreg #(.W(RES_W)) u_res_des (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (1'b0),
        .load_val_i ('0),
        .shift_i    (res_shift),
        .shift_in_i (pe_result_data),
        .q_o        (res_q)
    );

    assign unused_op_hi = ^op_q[OP_W-1:1];

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q + CNT_W'(1);
        dir_d            = dir_q;
        pf_d             = pf_q;
        conq_d           = conq_q;
        op_load          = 1'b0;
        op_shift         = 1'b0;
        res_shift        = 1'b0;
        in_ready         = 1'b0;
        out_valid        = 1'b0;
        pe_st            = STOP_ST;
        pe_extern_data   = 1'b0;
        pe_root_carry_in = 1'b0;
        accept           = 1'b0;
        out_hs           = 1'b0;

        case (state_q)
            SEQ_IDLE: begin
                in_ready = 1'b1;
                cnt_d    = '0;
                if (in_valid) begin
                    accept  = 1'b1;
                    op_load = 1'b1;
                    dir_d   = in_dir;
                    pf_d    = in_pathfunction;
                    state_d = SEQ_COST;
                end
            end
            SEQ_COST: begin
                pe_st          = COST_ST;
                pe_extern_data = op_q[0];
                op_shift       = 1'b1;
                // Carry injected on the last cost bit primes the ROOT subtraction
                if (cnt_q == CNT_W'(COST_W - 1)) begin
                    pe_root_carry_in = 1'b1;
                    state_d          = SEQ_ROOT;
                    cnt_d            = '0;
                end
            end
            SEQ_ROOT: begin
                pe_st          = ROOT_ST;
                pe_extern_data = op_q[0];
                op_shift       = 1'b1;
                if (cnt_q == CNT_W'(ROOT_W - 1)) begin
                    state_d = SEQ_SAVE;
                    cnt_d   = '0;
                end
            end
            SEQ_SAVE: begin
                pe_st     = SAVE_ST;
                res_shift = 1'b1;
                if (cnt_q == '0) begin
                    conq_d = pe_conquest;
                end
                if (cnt_q == CNT_W'(RES_W - 1)) begin
                    state_d = SEQ_DONE;
                    cnt_d   = '0;
                end
            end
            SEQ_DONE: begin
                out_valid = 1'b1;
                cnt_d     = '0;
                if (out_ready) begin
                    out_hs  = 1'b1;
                    state_d = SEQ_IDLE;
                end
            end
            default: begin
                state_d = SEQ_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= SEQ_IDLE;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            pf_q    <= 1'b0;
            conq_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            pf_q    <= pf_d;
            conq_q  <= conq_d;
        end
    end

    assign pe_state        = pe_st;
    assign pe_direction    = dir_q;
    assign pe_pathfunction = pf_q;
    assign out_word        = res_q;
    assign out_conquest    = conq_q;

`ifdef IDP_SEQ_STAT_EN
    logic [15:0] stat_cand_d, stat_cand_q;
    logic [15:0] stat_conq_d, stat_conq_q;

    always_comb begin
        stat_cand_d = stat_cand_q;
        stat_conq_d = stat_conq_q;
        if (accept && (stat_cand_q != 16'hFFFF)) begin
            stat_cand_d = stat_cand_q + 16'd1;
        end
        if (out_hs && conq_q && (stat_conq_q != 16'hFFFF)) begin
            stat_conq_d = stat_conq_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_cand_q <= '0;
            stat_conq_q <= '0;
        end else begin
            stat_cand_q <= stat_cand_d;
            stat_conq_q <= stat_conq_d;
        end
    end

    assign stat_cand = stat_cand_q;
    assign stat_conq = stat_conq_q;
`else
    logic unused_hs;
    assign unused_hs = accept ^ out_hs;
`endif

endmodule
